control_unit: RTL
=================

# control_unit

Hardwired sequencer that drives every control input of the single-bus CPU datapath: three-cycle instruction fetch, opcode decode from the instruction register, then per-class execute steps T3–T7. It sits beside the datapath and owns the only path that asserts register-file, Z, Y, HI/LO, PC, IR, MAR, MDR and RAM strobes. It also keeps a retired-instruction counter, a sticky illegal-opcode flag and a halt state.

## Interface
- No parameters.
- clock  in  1  system clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- start  in  1  level; leaves IDLE on first clock it is high
- ir_op  in  5  IR[31:27], current opcode from the datapath IR
- PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, MDRread, RAMwrite  out  1 each  datapath strobes
- Gra, Grb, Grc, Rin, Rout, BAout, RCout  out  1 each  select-and-encode controls
- RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, LOin  out  1 each  Y/Z/HI/LO controls
- run  out  1  high in any FETCH/EXEC state
- halted  out  1  high in HALT
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  sticky; set on an undefined opcode, cleared only by clear
- retired  out  16  count of completed instructions, wraps 0xFFFF→0x0000

## Operation
- States: IDLE, F0, F1, F2, T3, T4, T5, T6, T7, HALT.
- Opcodes: 00000 ld, 00001 ldi, 00010 st, 00011–01100 reg-reg ALU, 01101–01111 imm ALU, 10000 mul, 10001 div, 11010 nop, 11011 halt; all others illegal and executed as nop with illegal set.
- Fetch: F0 PCout MARin IncPC RZinLo; F1 RZoutLo PCin MDRread MDRin; F2 MDRout IRin.
- reg-reg: T3 Grb Rout RYin; T4 Grc Rout RZinLo RZinHi; T5 RZoutLo Gra Rin, done.
- imm ALU / ldi: T3 Grb (imm: Rout; ldi: BAout) RYin; T4 RCout RZinLo; T5 RZoutLo Gra Rin, done.
- ld: T3 Grb BAout RYin; T4 RCout RZinLo; T5 RZoutLo MARin; T6 MDRread MDRin; T7 MDRout Gra Rin, done.
- st: T3–T5 as ld; T6 Gra Rout MDRin (MDRread low); T7 RAMwrite, done.
- mul/div: T3 Gra Rout RYin; T4 Grb Rout RZinLo RZinHi; T5 RZoutLo LOin; T6 RZoutHi HIin, done.
- nop/illegal: T3 no strobes, done. halt: T3 → HALT, no done pulse, retired unchanged.
- Done cycle: next state F0 if start high, else IDLE; retired increments on the edge ending the done cycle.
- HALT is absorbing; only clear exits. start ignored in HALT.

## Timing
- Reset (async): state IDLE, every strobe 0, run 0, halted 0, instr_done 0, illegal 0, retired 0. Reset mid-instruction aborts immediately with no further strobes.
- Strobes are a function of state and ir_op only; no start→strobe combinational path. ir_op is only used in T3–T7 (IR stable; IRin only in F2).
- Latency start→F0: 1 cycle. Totals incl. fetch: reg-reg/imm/ldi 6, ld/st 8, mul/div 7, nop/illegal 4, halt 4 to HALT entry.
- At most one bus driver (Rout, BAout, RCout, PCout, MDRout, RZoutLo, RZoutHi) per cycle; MDRread never with RAMwrite.
- illegal sets at the edge ending T3 of an illegal opcode.

## Structure
- cpu_ctrl_pkg: opcode localparams, opcode-class decode function, state enum.
- Sub-module control_decode: combinational (state, ir_op) → strobe vector; control_unit holds state register, counter and flags.

## Test plan
- ir_op for IR 0x18918000 (add R1,R2,R3): F0–T5 strobes exactly as listed, instr_done in T5, retired 0→1, back to F0 with start high.
- IR 0x00900065 (ld R1,0x65(R2)): 8 cycles, MDRread+MDRin in T6 and F1 only, Gra Rin in T7.
- st then mul back to back: RAMwrite only in st T7; HIin in mul T6; retired +2; single bus driver every cycle.
- Opcode 10110: 4-cycle nop, illegal=1 and stays 1 through next add; clear resets it.
- IR 0xD8000000 (halt): HALT after T3, halted=1, run=0, start ignored 20 cycles, retired unchanged.
- clear asserted in ld T5 between edges: all strobes 0 at once, IDLE, retired 0; preload retired 0xFFFF then one nop → 0x0000.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, opcode classes, sequencer states and strobe bundle.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD        = 5'b00000;
  localparam logic [4:0] OP_LDI       = 5'b00001;
  localparam logic [4:0] OP_ST        = 5'b00010;
  localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01100;
  localparam logic [4:0] OP_IMM_FIRST = 5'b01101;
  localparam logic [4:0] OP_IMM_LAST  = 5'b01111;
  localparam logic [4:0] OP_MUL       = 5'b10000;
  localparam logic [4:0] OP_DIV       = 5'b10001;
  localparam logic [4:0] OP_NOP       = 5'b11010;
  localparam logic [4:0] OP_HALT      = 5'b11011;

  typedef enum logic [3:0] {
    IDLE, F0, F1, F2, T3, T4, T5, T6, T7, HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_LD, CLS_LDI, CLS_ST, CLS_ALU, CLS_IMM, CLS_MULDIV,
    CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } opClass_t;

  typedef struct packed {
    logic pcOut;   logic pcIn;    logic incPc;   logic irIn;
    logic marIn;   logic mdrIn;   logic mdrOut;  logic mdrRead;
    logic ramWrite;
    logic gra;     logic grb;     logic grc;     logic rIn;
    logic rOut;    logic baOut;   logic rcOut;
    logic ryIn;    logic rzInLo;  logic rzInHi;  logic rzOutLo;
    logic rzOutHi; logic hiIn;    logic loIn;
  } ctrl_t;

  function automatic opClass_t decodeClass(input logic [4:0] op);
    opClass_t cls;
    if (op == OP_LD)                                cls = CLS_LD;
    else if (op == OP_LDI)                          cls = CLS_LDI;
    else if (op == OP_ST)                           cls = CLS_ST;
    else if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) cls = CLS_ALU;
    else if (op >= OP_IMM_FIRST && op <= OP_IMM_LAST) cls = CLS_IMM;
    else if (op == OP_MUL || op == OP_DIV)          cls = CLS_MULDIV;
    else if (op == OP_NOP)                          cls = CLS_NOP;
    else if (op == OP_HALT)                         cls = CLS_HALT;
    else                                            cls = CLS_ILLEGAL;
    return cls;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decode from sequencer state and current opcode.
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] irOp,
  output ctrl_t      ctrl,
  output logic       lastStep,
  output logic       haltStep,
  output logic       illegalStep
);

  opClass_t cls;
  assign cls = decodeClass(irOp);

  // Strobes per step; opcode class only matters in T3-T7
  always_comb begin
    ctrl        = '0;
    lastStep    = 1'b0;
    haltStep    = 1'b0;
    illegalStep = 1'b0;
    case (state)
      F0: begin ctrl.pcOut = 1'b1; ctrl.marIn = 1'b1; ctrl.incPc = 1'b1; ctrl.rzInLo = 1'b1; end
      F1: begin ctrl.rzOutLo = 1'b1; ctrl.pcIn = 1'b1; ctrl.mdrRead = 1'b1; ctrl.mdrIn = 1'b1; end
      F2: begin ctrl.mdrOut = 1'b1; ctrl.irIn = 1'b1; end
      T3: case (cls)
        CLS_ALU, CLS_IMM: begin ctrl.grb = 1'b1; ctrl.rOut = 1'b1; ctrl.ryIn = 1'b1; end
        CLS_LDI, CLS_LD, CLS_ST: begin ctrl.grb = 1'b1; ctrl.baOut = 1'b1; ctrl.ryIn = 1'b1; end
        CLS_MULDIV: begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.ryIn = 1'b1; end
        CLS_HALT: haltStep = 1'b1;
        CLS_ILLEGAL: begin lastStep = 1'b1; illegalStep = 1'b1; end
        default: lastStep = 1'b1;
      endcase
      T4: case (cls)
        CLS_ALU: begin ctrl.grc = 1'b1; ctrl.rOut = 1'b1; ctrl.rzInLo = 1'b1; ctrl.rzInHi = 1'b1; end
        CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin ctrl.rcOut = 1'b1; ctrl.rzInLo = 1'b1; end
        CLS_MULDIV: begin ctrl.grb = 1'b1; ctrl.rOut = 1'b1; ctrl.rzInLo = 1'b1; ctrl.rzInHi = 1'b1; end
        default: ;
      endcase
      T5: case (cls)
        CLS_ALU, CLS_IMM, CLS_LDI: begin
          ctrl.rzOutLo = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; lastStep = 1'b1;
        end
        CLS_LD, CLS_ST: begin ctrl.rzOutLo = 1'b1; ctrl.marIn = 1'b1; end
        CLS_MULDIV: begin ctrl.rzOutLo = 1'b1; ctrl.loIn = 1'b1; end
        default: ;
      endcase
      T6: case (cls)
        CLS_LD: begin ctrl.mdrRead = 1'b1; ctrl.mdrIn = 1'b1; end
        CLS_ST: begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.mdrIn = 1'b1; end
        CLS_MULDIV: begin ctrl.rzOutHi = 1'b1; ctrl.hiIn = 1'b1; lastStep = 1'b1; end
        default: ;
      endcase
      T7: case (cls)
        CLS_LD: begin ctrl.mdrOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; lastStep = 1'b1; end
        CLS_ST: begin ctrl.ramWrite = 1'b1; lastStep = 1'b1; end
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired CPU sequencer: state register, retired counter, illegal/halt status.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  ir_op,
  output logic        PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, MDRread, RAMwrite,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, RCout,
  output logic        RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, LOin,
  output logic        run,
  output logic        halted,
  output logic        instr_done,
  output logic        illegal,
  output logic [15:0] retired
);

  state_t      stateQ, stateD;
  ctrl_t       ctrl;
  logic        lastStep, haltStep, illegalStep;
  logic        illegalQ;
  logic [15:0] retiredQ;

  control_decode uDecode (
    .state       (stateQ),
    .irOp        (ir_op),
    .ctrl        (ctrl),
    .lastStep    (lastStep),
    .haltStep    (haltStep),
    .illegalStep (illegalStep)
  );

  // Next-state sequencing; start only steers transitions, never strobes
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: if (start) stateD = F0;
      F0:   stateD = F1;
      F1:   stateD = F2;
      F2:   stateD = T3;
      T3, T4, T5, T6, T7: begin
        if (haltStep)      stateD = HALT;
        else if (lastStep) stateD = start ? F0 : IDLE;
        else begin
          case (stateQ)
            T3:      stateD = T4;
            T4:      stateD = T5;
            T5:      stateD = T6;
            T6:      stateD = T7;
            default: stateD = IDLE;
          endcase
        end
      end
      HALT:    stateD = HALT;
      default: stateD = IDLE;
    endcase
  end

  // State register, retired counter and sticky illegal flag
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      stateQ   <= IDLE;
      retiredQ <= '0;
      illegalQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (lastStep)    retiredQ <= retiredQ + 16'd1;
      if (illegalStep) illegalQ <= 1'b1;
    end
  end

  assign PCout      = ctrl.pcOut;
  assign PCin       = ctrl.pcIn;
  assign IncPC      = ctrl.incPc;
  assign IRin       = ctrl.irIn;
  assign MARin      = ctrl.marIn;
  assign MDRin      = ctrl.mdrIn;
  assign MDRout     = ctrl.mdrOut;
  assign MDRread    = ctrl.mdrRead;
  assign RAMwrite   = ctrl.ramWrite;
  assign Gra        = ctrl.gra;
  assign Grb        = ctrl.grb;
  assign Grc        = ctrl.grc;
  assign Rin        = ctrl.rIn;
  assign Rout       = ctrl.rOut;
  assign BAout      = ctrl.baOut;
  assign RCout      = ctrl.rcOut;
  assign RYin       = ctrl.ryIn;
  assign RZinLo     = ctrl.rzInLo;
  assign RZinHi     = ctrl.rzInHi;
  assign RZoutLo    = ctrl.rzOutLo;
  assign RZoutHi    = ctrl.rzOutHi;
  assign HIin       = ctrl.hiIn;
  assign LOin       = ctrl.loIn;
  assign run        = (stateQ != IDLE) && (stateQ != HALT);
  assign halted     = (stateQ == HALT);
  assign instr_done = lastStep;
  assign illegal    = illegalQ;
  assign retired    = retiredQ;

endmodule
